// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - register file with dual write ports, optional bypass and busy scoreboard
module register_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int SP_INDEX = 2,
    parameter int SP_RESET = 1024,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   readRegister,
    output logic [NREAD*XLEN-1:0] dataOut,
    output logic [NREAD-1:0]      readReady,
    input  logic                  writeEnable0,
    input  logic [AW-1:0]         writeRegister0,
    input  logic [XLEN-1:0]       dataIn0,
    input  logic                  writeEnable1,
    input  logic [AW-1:0]         writeRegister1,
    input  logic [XLEN-1:0]       dataIn1,
    input  logic                  reserveEnable,
    input  logic [AW-1:0]         reserveRegister,
    output logic [AW:0]           busyCount
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_busy_count;

    logic w_we0;
    logic w_we1;
    logic w_res;
    logic w_cnt_inc;
    logic w_cnt_dec;

    // Register 0 is hardwired: writes and reservations to it are dropped here.
    assign w_we0 = writeEnable0 && (writeRegister0 != '0);
    assign w_we1 = writeEnable1 && (writeRegister1 != '0);
    assign w_res = reserveEnable && (reserveRegister != '0);

    // A reserve on the register being released keeps it busy, so no decrement.
    assign w_cnt_inc = w_res && !r_busy[reserveRegister];
    assign w_cnt_dec = w_we1 && r_busy[writeRegister1]
                       && !(w_res && (reserveRegister == writeRegister1));

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_read
            logic [AW-1:0] w_addr;
            logic          w_hit0;
            logic          w_hit1;

            assign w_addr = readRegister[gi*AW +: AW];
            assign w_hit0 = BYPASS && writeEnable0 && (writeRegister0 == w_addr);
            assign w_hit1 = BYPASS && writeEnable1 && (writeRegister1 == w_addr);

            always_comb begin
                dataOut[gi*XLEN +: XLEN] = r_regs[w_addr];
                if (w_addr == '0) begin
                    dataOut[gi*XLEN +: XLEN] = '0;
                end else if (w_hit1) begin
                    dataOut[gi*XLEN +: XLEN] = dataIn1;
                end else if (w_hit0) begin
                    dataOut[gi*XLEN +: XLEN] = dataIn0;
                end
            end

            assign readReady[gi] = (w_addr == '0) || !r_busy[w_addr] || w_hit1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= (i == SP_INDEX) ? XLEN'(SP_RESET) : '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_we0) begin
                r_regs[writeRegister0] <= dataIn0;
            end
            if (w_we1) begin
                r_regs[writeRegister1] <= dataIn1;
                r_busy[writeRegister1] <= 1'b0;
            end
            if (w_res) begin
                r_busy[reserveRegister] <= 1'b1;
            end
            if (w_cnt_inc && !w_cnt_dec) begin
                r_busy_count <= r_busy_count + 1'b1;
            end else if (w_cnt_dec && !w_cnt_inc) begin
                r_busy_count <= r_busy_count - 1'b1;
            end
        end
    end

    assign busyCount = r_busy_count;

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - directed self-checking bench for register_file_sb
module tb_register_file_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2*AW-1:0]   readRegister;
    logic [2*XLEN-1:0] dataOut, dataOut_nb;
    logic [1:0]        readReady, readReady_nb;
    logic              writeEnable0, writeEnable1, reserveEnable;
    logic [AW-1:0]     writeRegister0, writeRegister1, reserveRegister;
    logic [XLEN-1:0]   dataIn0, dataIn1;
    logic [AW:0]       busyCount, busyCount_nb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_sb #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .readRegister(readRegister), .dataOut(dataOut),
        .readReady(readReady), .writeEnable0(writeEnable0), .writeRegister0(writeRegister0),
        .dataIn0(dataIn0), .writeEnable1(writeEnable1), .writeRegister1(writeRegister1),
        .dataIn1(dataIn1), .reserveEnable(reserveEnable), .reserveRegister(reserveRegister),
        .busyCount(busyCount)
    );

    register_file_sb #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .readRegister(readRegister), .dataOut(dataOut_nb),
        .readReady(readReady_nb), .writeEnable0(writeEnable0), .writeRegister0(writeRegister0),
        .dataIn0(dataIn0), .writeEnable1(writeEnable1), .writeRegister1(writeRegister1),
        .dataIn1(dataIn1), .reserveEnable(reserveEnable), .reserveRegister(reserveRegister),
        .busyCount(busyCount_nb)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        writeEnable0 = 1'b0; writeEnable1 = 1'b0; reserveEnable = 1'b0;
        writeRegister0 = '0; writeRegister1 = '0; reserveRegister = '0;
        dataIn0 = '0; dataIn1 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        readRegister = {a1, a0};
        #1;
    endtask

    task automatic reserve(input logic [AW-1:0] r);
        reserveEnable = 1'b1; reserveRegister = r;
        tick();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        readRegister = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(5'd2, 5'd1);
        chk("rst_sp",      dataOut[31:0], 64'd1024);
        chk("rst_x1",      dataOut[63:32], 64'd0);
        chk("rst_cnt",     busyCount, 64'd0);
        chk("rst_ready",   readReady, 64'd3);
        chk("rst_sp_nb",   dataOut_nb[31:0], 64'd1024);

        writeEnable0 = 1'b1; writeRegister0 = 5'd5; dataIn0 = 32'hDEADBEEF;
        rd(5'd5, 5'd0);
        chk("byp_w0",      dataOut[31:0], 64'hDEADBEEF);
        chk("nobyp_w0",    dataOut_nb[31:0], 64'd0);
        tick();
        chk("stored_x5",   dataOut[31:0], 64'hDEADBEEF);
        chk("stored_x5_nb", dataOut_nb[31:0], 64'hDEADBEEF);

        writeEnable0 = 1'b1; writeRegister0 = 5'd7; dataIn0 = 32'h11;
        writeEnable1 = 1'b1; writeRegister1 = 5'd7; dataIn1 = 32'h22;
        rd(5'd7, 5'd5);
        chk("byp_dual",    dataOut[31:0], 64'h22);
        tick();
        chk("dual_x7",     dataOut[31:0], 64'h22);
        chk("dual_x7_nb",  dataOut_nb[31:0], 64'h22);

        writeEnable0 = 1'b1; writeRegister0 = 5'd0; dataIn0 = 32'hFF;
        rd(5'd0, 5'd0);
        chk("x0_byp",      dataOut[31:0], 64'd0);
        tick();
        chk("x0_stored",   dataOut[31:0], 64'd0);
        chk("x0_ready",    readReady, 64'd3);

        reserve(5'd9);
        rd(5'd9, 5'd0);
        chk("res9_ready",  readReady, 64'd2);
        chk("res9_cnt",    busyCount, 64'd1);

        writeEnable1 = 1'b1; writeRegister1 = 5'd9; dataIn1 = 32'h55;
        #1;
        chk("w1_byp_rdy",  readReady, 64'd3);
        chk("w1_byp_data", dataOut[31:0], 64'h55);
        chk("w1_nb_rdy",   readReady_nb, 64'd2);
        chk("w1_nb_data",  dataOut_nb[31:0], 64'd0);
        tick();
        chk("rel9_cnt",    busyCount, 64'd0);
        chk("rel9_ready",  readReady, 64'd3);
        chk("rel9_data",   dataOut[31:0], 64'h55);

        reserve(5'd9);
        chk("rer9_cnt",    busyCount, 64'd1);
        reserveEnable = 1'b1; reserveRegister = 5'd9;
        writeEnable1 = 1'b1; writeRegister1 = 5'd9; dataIn1 = 32'h66;
        tick();
        chk("same_data",   dataOut[31:0], 64'h66);
        chk("same_ready",  readReady, 64'd2);
        chk("same_cnt",    busyCount, 64'd1);

        writeEnable1 = 1'b1; writeRegister1 = 5'd9; dataIn1 = 32'h66;
        tick();
        chk("clr9_cnt",    busyCount, 64'd0);

        rd(5'd3, 5'd4);
        reserve(5'd3);
        chk("r3_cnt",      busyCount, 64'd1);
        reserve(5'd4);
        chk("r4_cnt",      busyCount, 64'd2);
        reserve(5'd3);
        chk("r3b_cnt",     busyCount, 64'd2);
        chk("r34_ready",   readReady, 64'd0);

        reserveEnable = 1'b1; reserveRegister = 5'd10;
        writeEnable1 = 1'b1; writeRegister1 = 5'd3; dataIn1 = 32'h33;
        tick();
        chk("swap_cnt",    busyCount, 64'd2);
        chk("swap_ready",  readReady, 64'd1);

        writeEnable0 = 1'b1; writeRegister0 = 5'd5; dataIn0 = 32'h1234;
        reserveEnable = 1'b1; reserveRegister = 5'd11;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rd(5'd5, 5'd2);
        chk("rst2_cnt",    busyCount, 64'd0);
        chk("rst2_x5",     dataOut[31:0], 64'd0);
        chk("rst2_sp",     dataOut[63:32], 64'd1024);
        chk("rst2_ready",  readReady, 64'd3);
        rd(5'd3, 5'd10);
        chk("rst2_ready2", readReady, 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
